// File: rtl/spi_pkg.sv
// Shared constants for the SPI byte shifter slice.
//   - default sclk half-periods per speed code
//   - CRC16-CCITT generator polynomial
//   - shifter state encoding and speed code names
package spi_pkg;

   localparam int HALF0_DEF = 16;   // init rate, ~221 kHz at 7.09 MHz clk
   localparam int HALF1_DEF = 4;
   localparam int HALF2_DEF = 2;
   localparam int HALF3_DEF = 1;

   localparam logic [15:0] CRC_POLY = 16'h1021;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;

   localparam logic [1:0] SPD_INIT  = 2'd0;
   localparam logic [1:0] SPD_SLOW  = 2'd1;
   localparam logic [1:0] SPD_FAST  = 2'd2;
   localparam logic [1:0] SPD_FULL  = 2'd3;

endpackage

// File: rtl/spi_byte_shifter_if.sv
// Register-front-end side of the byte shifter.
//   master : front end (drives strobes/data, reads result/busy/crc)
//   slave  : shifter
interface spi_byte_shifter_if;
   logic        start_write;
   logic        start_read;
   logic [7:0]  shift_in;
   logic [7:0]  shift_out;
   logic [1:0]  speed;
   logic        crc_reset;
   logic        crc_source;
   logic [15:0] crc_out;
   logic        busy;

   modport master (
      output start_write, start_read, shift_in, speed, crc_reset, crc_source,
      input  shift_out, crc_out, busy
   );

   modport slave (
      input  start_write, start_read, shift_in, speed, crc_reset, crc_source,
      output shift_out, crc_out, busy
   );
endinterface

// File: rtl/crc16_serial.sv
// Bit-serial CRC16, MSB-first, init 0, no reflection, no final XOR.
//   clk, rst : clock, async active-high reset (clears crc)
//   clr      : synchronous clear, wins over en
//   en       : advance one bit
//   bit_in   : data bit
//   crc      : current remainder
module crc16_serial
   import spi_pkg::*;
#(
   parameter logic [15:0] POLY = CRC_POLY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         crc <= 16'h0000;
      else if (clr)
         crc <= 16'h0000;
      else if (en)
         crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? POLY : 16'h0000);
   end

endmodule

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master byte shifter behind the 68k register front end.
//   clk, rst : shifter clock, async active-high reset
//   bus      : strobes, tx/rx byte, speed, CRC control/result, busy
//   miso     : serial in, sampled on the sclk rising edge
//   mosi     : serial out, MSB first, idles high
//   sclk     : serial clock, idles low
// One byte takes 16*half clk cycles; half is latched from speed at start.
module spi_byte_shifter
   import spi_pkg::*;
#(
   parameter int          HALF0 = HALF0_DEF,
   parameter int          HALF1 = HALF1_DEF,
   parameter int          HALF2 = HALF2_DEF,
   parameter int          HALF3 = HALF3_DEF,
   parameter logic [15:0] POLY  = CRC_POLY
) (
   input  logic              clk,
   input  logic              rst,
   spi_byte_shifter_if.slave bus,
   input  logic              miso,
   output logic              mosi,
   output logic              sclk
);

   logic [1:0] state;
   logic [4:0] half;
   logic [4:0] half_sel;
   logic [4:0] cnt;
   logic [2:0] bitcnt;
   logic [7:0] tx;
   logic [7:0] rx;
   logic [7:0] shift_out_q;
   logic       busy_q;
   logic       start;
   logic       crc_en;

   always_comb begin
      half_sel = 5'(HALF0);
      case (bus.speed)
         SPD_INIT: half_sel = 5'(HALF0);
         SPD_SLOW: half_sel = 5'(HALF1);
         SPD_FAST: half_sel = 5'(HALF2);
         SPD_FULL: half_sel = 5'(HALF3);
         default:  half_sel = 5'(HALF0);
      endcase
   end

   assign start  = (state == ST_IDLE) && (bus.start_write || bus.start_read);
   // miso sampling edge is also the CRC step; mosi is the registered bit on the wire
   assign crc_en = (state == ST_LOW) && (cnt == 5'd0);

   // tx is shifted left each bit so tx[7] is always the bit on mosi
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         sclk        <= 1'b0;
         mosi        <= 1'b1;
         busy_q      <= 1'b0;
         shift_out_q <= 8'hFF;
         tx          <= 8'hFF;
         rx          <= 8'h00;
         cnt         <= 5'd0;
         bitcnt      <= 3'd0;
         half        <= 5'(HALF0);
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  half   <= half_sel;
                  tx     <= bus.start_write ? bus.shift_in : 8'hFF;
                  mosi   <= bus.start_write ? bus.shift_in[7] : 1'b1;
                  bitcnt <= 3'd7;
                  cnt    <= half_sel - 5'd1;
                  state  <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (cnt == 5'd0) begin
                  sclk  <= 1'b1;
                  rx    <= {rx[6:0], miso};
                  cnt   <= half - 5'd1;
                  state <= ST_HIGH;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            ST_HIGH: begin
               if (cnt == 5'd0) begin
                  sclk <= 1'b0;
                  if (bitcnt == 3'd0) begin
                     shift_out_q <= rx;
                     busy_q      <= 1'b0;
                     mosi        <= 1'b1;
                     state       <= ST_IDLE;
                  end else begin
                     bitcnt <= bitcnt - 3'd1;
                     tx     <= {tx[6:0], 1'b1};
                     mosi   <= tx[6];
                     cnt    <= half - 5'd1;
                     state  <= ST_LOW;
                  end
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   crc16_serial #(.POLY(POLY)) u_crc (
      .clk    (clk),
      .rst    (rst),
      .clr    (bus.crc_reset),
      .en     (crc_en),
      .bit_in (bus.crc_source ? miso : mosi),
      .crc    (bus.crc_out)
   );

   assign bus.shift_out = shift_out_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Scenario bench for spi_byte_shifter: expected bytes are queued when a
// transfer is launched and popped when busy falls.
module tb_spi_byte_shifter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mosi, sclk, miso;
   logic [1:0] miso_mode = 2'd0;   // 0: tied 0, 1: tied 1, 2: loop to mosi

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   spi_byte_shifter_if bus ();

   assign miso = (miso_mode == 2'd2) ? mosi : miso_mode[0];

   spi_byte_shifter dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .miso (miso),
      .mosi (mosi),
      .sclk (sclk)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: sim time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   // Launches one transfer and observes it until busy drops.
   // inj_at > 0 raises start_write (and alters shift_in/speed) on that cycle.
   task automatic run_byte(input logic wr, input logic rd, input logic [7:0] din,
                           input logic [1:0] spd, input logic crc_clr,
                           input int inj_at, input logic [7:0] inj_data,
                           output int busy_cyc, output logic [7:0] mbits,
                           output int period, output logic saw0, output logic tmo);
      int   cyc, r0, r1, nr;
      logic prev;
      @(negedge clk);
      bus.start_write = wr;
      bus.start_read  = rd;
      bus.shift_in    = din;
      bus.speed       = spd;
      bus.crc_reset   = crc_clr;
      @(posedge clk); #1;
      bus.start_write = 1'b0;
      bus.start_read  = 1'b0;
      bus.crc_reset   = 1'b0;
      cyc = 0; nr = 0; r0 = 0; r1 = 0; prev = 1'b0; mbits = 8'h00; saw0 = 1'b0;
      while (bus.busy === 1'b1 && cyc < 600) begin
         cyc++;
         if (sclk === 1'b1 && prev === 1'b0) begin
            mbits = {mbits[6:0], mosi};
            if (nr == 0) r0 = cyc;
            else if (nr == 1) r1 = cyc;
            nr++;
         end
         prev = sclk;
         if (mosi === 1'b0) saw0 = 1'b1;
         if (cyc == inj_at) begin
            bus.start_write = 1'b1;
            bus.shift_in    = inj_data;
            bus.speed       = 2'd0;
         end else begin
            bus.start_write = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.start_write = 1'b0;
      busy_cyc = cyc;
      period   = r1 - r0;
      tmo      = (cyc >= 600);
   endtask

   task automatic test_reset();
      n_tests++;
      if (sclk !== 1'b0 || mosi !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pins: got sclk=%b mosi=%b busy=%b, required 0 1 0", sclk, mosi, bus.busy);
      end
      n_tests++;
      if (bus.shift_out !== 8'hFF || bus.crc_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_regs: got shift_out=%h crc=%h, required ff 0000", bus.shift_out, bus.crc_out);
      end
   endtask

   task automatic test_write_fast();
      int bc, per; logic [7:0] mb, got; logic s0, tmo;
      miso_mode = 2'd2;
      exp_q.push_back(8'hA5);
      run_byte(1'b1, 1'b0, 8'hA5, 2'd3, 1'b0, 0, 8'h00, bc, mb, per, s0, tmo);
      got = exp_q.pop_front();
      n_tests++;
      if (tmo || bc !== 16) begin n_fail++; $display("FAIL wr3_busy: got %0d cycles, required 16", bc); end
      n_tests++;
      if (per !== 2) begin n_fail++; $display("FAIL wr3_period: got %0d, required 2", per); end
      n_tests++;
      if (mb !== 8'hA5) begin n_fail++; $display("FAIL wr3_mosi: got %h, required a5", mb); end
      n_tests++;
      if (bus.shift_out !== got) begin n_fail++; $display("FAIL wr3_rx: got %h, required %h", bus.shift_out, got); end
   endtask

   task automatic test_read_slow();
      int bc, per; logic [7:0] mb, got; logic s0, tmo;
      miso_mode = 2'd0;
      exp_q.push_back(8'h00);
      run_byte(1'b0, 1'b1, 8'h12, 2'd0, 1'b0, 0, 8'h00, bc, mb, per, s0, tmo);
      got = exp_q.pop_front();
      n_tests++;
      if (tmo || bc !== 256) begin n_fail++; $display("FAIL rd0_busy: got %0d cycles, required 256", bc); end
      n_tests++;
      if (per !== 32) begin n_fail++; $display("FAIL rd0_period: got %0d, required 32", per); end
      n_tests++;
      if (s0 !== 1'b0 || mb !== 8'hFF) begin n_fail++; $display("FAIL rd0_mosi: got low=%b bits=%h, required 0 ff", s0, mb); end
      n_tests++;
      if (bus.shift_out !== got) begin n_fail++; $display("FAIL rd0_rx: got %h, required %h", bus.shift_out, got); end
   endtask

   task automatic test_speeds();
      int bc, per; logic [7:0] mb; logic s0, tmo;
      miso_mode = 2'd2;
      run_byte(1'b1, 1'b0, 8'h3C, 2'd1, 1'b0, 0, 8'h00, bc, mb, per, s0, tmo);
      n_tests++;
      if (bc !== 64 || per !== 8) begin n_fail++; $display("FAIL spd1: got busy=%0d period=%0d, required 64 8", bc, per); end
      run_byte(1'b1, 1'b0, 8'hC3, 2'd2, 1'b0, 0, 8'h00, bc, mb, per, s0, tmo);
      n_tests++;
      if (bc !== 32 || per !== 4 || bus.shift_out !== 8'hC3) begin
         n_fail++; $display("FAIL spd2: got busy=%0d period=%0d rx=%h, required 32 4 c3", bc, per, bus.shift_out);
      end
   endtask

   task automatic test_crc_tx();
      int bc, per; logic [7:0] mb; logic s0, tmo;
      string msg = "123456789";
      miso_mode = 2'd0;
      bus.crc_source = 1'b0;
      // dirty the CRC first so the clear coincident with the first start matters
      run_byte(1'b1, 1'b0, 8'h5E, 2'd3, 1'b0, 0, 8'h00, bc, mb, per, s0, tmo);
      n_tests++;
      if (bus.crc_out === 16'h0000) begin n_fail++; $display("FAIL crc_dirty: got %h, required nonzero", bus.crc_out); end
      for (int i = 0; i < 9; i++)
         run_byte(1'b1, 1'b0, msg[i], 2'd3, (i == 0), 0, 8'h00, bc, mb, per, s0, tmo);
      n_tests++;
      if (bus.crc_out !== 16'h31C3) begin n_fail++; $display("FAIL crc_tx: got %h, required 31c3", bus.crc_out); end
   endtask

   task automatic test_crc_rx();
      int bc, per, bad; logic [7:0] mb; logic s0, tmo;
      miso_mode = 2'd1;
      bus.crc_source = 1'b1;
      @(negedge clk); bus.crc_reset = 1'b1;
      @(negedge clk); bus.crc_reset = 1'b0;
      n_tests++;
      if (bus.crc_out !== 16'h0000) begin n_fail++; $display("FAIL crc_clr: got %h, required 0000", bus.crc_out); end
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         exp_q.push_back(8'hFF);
         run_byte(1'b0, 1'b1, 8'h00, 2'd3, 1'b0, 0, 8'h00, bc, mb, per, s0, tmo);
         if (tmo || bc != 16 || bus.shift_out !== exp_q.pop_front()) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL crc_rx_bytes: got %0d bad transfers, required 0", bad); end
      n_tests++;
      if (bus.crc_out !== 16'h7FA1) begin n_fail++; $display("FAIL crc_rx: got %h, required 7fa1", bus.crc_out); end
      bus.crc_source = 1'b0;
   endtask

   task automatic test_back_to_back();
      int bc, per; logic [7:0] mb, got; logic s0, tmo;
      miso_mode = 2'd2;
      exp_q.push_back(8'h3C);
      run_byte(1'b1, 1'b0, 8'h3C, 2'd3, 1'b0, 5, 8'hC3, bc, mb, per, s0, tmo);
      got = exp_q.pop_front();
      n_tests++;
      if (bc !== 16 || mb !== 8'h3C || bus.shift_out !== got) begin
         n_fail++; $display("FAIL midstart: got busy=%0d mosi=%h rx=%h, required 16 3c %h", bc, mb, bus.shift_out, got);
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midstart_idle: got busy=%b, required 0", bus.busy); end
      exp_q.push_back(8'h5A);
      run_byte(1'b1, 1'b1, 8'h5A, 2'd3, 1'b0, 0, 8'h00, bc, mb, per, s0, tmo);
      got = exp_q.pop_front();
      n_tests++;
      if (bc !== 16 || mb !== 8'h5A || bus.shift_out !== got) begin
         n_fail++; $display("FAIL both_starts: got busy=%0d mosi=%h rx=%h, required 16 5a %h", bc, mb, bus.shift_out, got);
      end
   endtask

   task automatic test_reset_mid();
      int bc, per; logic [7:0] mb; logic s0, tmo;
      miso_mode = 2'd2;
      @(negedge clk);
      bus.start_write = 1'b1; bus.shift_in = 8'h0F; bus.speed = 2'd3;
      @(posedge clk); #1;
      bus.start_write = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_tests++;
      if (sclk !== 1'b0 || mosi !== 1'b1 || bus.busy !== 1'b0 || bus.shift_out !== 8'hFF || bus.crc_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL rst_mid: got sclk=%b mosi=%b busy=%b rx=%h crc=%h, required 0 1 0 ff 0000",
                  sclk, mosi, bus.busy, bus.shift_out, bus.crc_out);
      end
      @(negedge clk); rst = 1'b0;
      exp_q.push_back(8'h96);
      run_byte(1'b1, 1'b0, 8'h96, 2'd3, 1'b0, 0, 8'h00, bc, mb, per, s0, tmo);
      n_tests++;
      if (bc !== 16 || mb !== 8'h96 || bus.shift_out !== exp_q.pop_front()) begin
         n_fail++; $display("FAIL rst_after: got busy=%0d mosi=%h rx=%h, required 16 96 96", bc, mb, bus.shift_out);
      end
   endtask

   initial begin
      bus.start_write = 1'b0;
      bus.start_read  = 1'b0;
      bus.shift_in    = 8'h00;
      bus.speed       = 2'd0;
      bus.crc_reset   = 1'b0;
      bus.crc_source  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk); rst = 1'b0;
      test_write_fast();
      test_read_slow();
      test_speeds();
      test_crc_tx();
      test_crc_rx();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
